// File: rtl/aeses_host_pkg.sv
// Shared types and defaults for the AESES UART host interface.
package aeses_host_pkg;

    localparam int KEY_BYTES_DEF = 32;
    localparam int BLK_BYTES_DEF = 16;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        S_KEY,
        S_KEYLD,
        S_BLK,
        S_START,
        S_WAIT,
        S_TX
    } state_t;

endpackage

// File: rtl/aeses_uart_host_if.sv
// Device-side AESES UART byte protocol: gathers key and data blocks from the
// UART receiver, launches the AES core per block and streams results back out.
module aeses_uart_host_if
    import aeses_host_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEF,
    parameter int BLK_BYTES = BLK_BYTES_DEF,
    parameter int CNT_W     = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic                   rx_frame_err,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [8*KEY_BYTES-1:0] aes_key,
    output logic                   aes_key_load,
    output logic [8*BLK_BYTES-1:0] aes_din,
    output logic                   aes_start,
    input  logic                   aes_done,
    input  logic [8*BLK_BYTES-1:0] aes_dout,
    output logic                   key_loaded,
    output logic                   busy,
    output logic                   overrun,
    output logic                   frame_err
);

    localparam int KW = 8 * KEY_BYTES;
    localparam int BW = 8 * BLK_BYTES;
    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLK_BYTES - 1);

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;
    logic [KW-1:0]    key_sr;
    logic [BW-1:0]    din_sr;
    logic [BW-1:0]    tx_sr;
    logic             rx_good;

    // A frame-errored byte never counts as a data byte, in any state.
    assign rx_good = rx_valid && !rx_frame_err;

    assign aes_key = key_sr;
    assign aes_din = din_sr;
    assign tx_data = tx_sr[BW-1 -: 8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_KEY;
            byte_cnt     <= '0;
            key_sr       <= '0;
            din_sr       <= '0;
            tx_sr        <= '0;
            tx_valid     <= 1'b0;
            aes_key_load <= 1'b0;
            aes_start    <= 1'b0;
            key_loaded   <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            aes_key_load <= 1'b0;
            aes_start    <= 1'b0;

            if (rx_valid && rx_frame_err) begin
                frame_err <= 1'b1;
            end
            if (rx_good && (state inside {S_KEYLD, S_START, S_WAIT, S_TX})) begin
                overrun <= 1'b1;
            end

            case (state)
                S_KEY: begin
                    if (rx_good) begin
                        key_sr <= {key_sr[KW-9:0], rx_data};
                        if (byte_cnt == KEY_LAST) begin
                            byte_cnt     <= '0;
                            aes_key_load <= 1'b1;
                            key_loaded   <= 1'b1;
                            state        <= S_KEYLD;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                S_KEYLD: begin
                    byte_cnt <= '0;
                    state    <= S_BLK;
                end
                S_BLK: begin
                    if (rx_good) begin
                        din_sr <= {din_sr[BW-9:0], rx_data};
                        if (byte_cnt == BLK_LAST) begin
                            byte_cnt  <= '0;
                            aes_start <= 1'b1;
                            busy      <= 1'b1;
                            state     <= S_START;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (aes_done) begin
                        tx_sr    <= aes_dout;
                        tx_valid <= 1'b1;
                        byte_cnt <= '0;
                        state    <= S_TX;
                    end
                end
                S_TX: begin
                    // tx_sr only moves on a handshake, so tx_data holds while stalled.
                    if (tx_valid && tx_ready) begin
                        tx_sr <= {tx_sr[BW-9:0], 8'h00};
                        if (byte_cnt == BLK_LAST) begin
                            byte_cnt <= '0;
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            state    <= S_BLK;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_KEY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aeses_uart_host_if.sv
// Self-checking bench for aeses_uart_host_if with a mock AES core and UART sink.
module tb_aeses_uart_host_if;

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         rx_frame_err = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b1;
    logic [255:0] aes_key;
    logic         aes_key_load;
    logic [127:0] aes_din;
    logic         aes_start;
    logic         aes_done = 1'b0;
    logic [127:0] aes_dout = '0;
    logic         key_loaded;
    logic         busy;
    logic         overrun;
    logic         frame_err;

    aeses_uart_host_if dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .aes_key(aes_key), .aes_key_load(aes_key_load),
        .aes_din(aes_din), .aes_start(aes_start),
        .aes_done(aes_done), .aes_dout(aes_dout),
        .key_loaded(key_loaded), .busy(busy),
        .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Mock AES: the known test vector, otherwise an easily predicted scramble.
    function automatic logic [127:0] aes_model(input logic [127:0] d);
        if (d == PT) return CT;
        return {d[63:0], d[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    // Mock AES core: answers each start 40 cycles later; can emit stray done pulses.
    bit           pending = 1'b0;
    int           wcnt = 0;
    logic [127:0] din_cap = '0;
    int           start_count = 0;
    int           done_cyc = 0;
    int           spur_req = 0;
    int           spur_done = 0;
    always @(negedge clk) begin
        aes_done = 1'b0;
        if (!rst) begin
            pending = 1'b0;
        end else if (pending) begin
            wcnt--;
            if (wcnt == 0) begin
                aes_done = 1'b1;
                aes_dout = aes_model(din_cap);
                done_cyc = cyc;
                pending  = 1'b0;
            end
        end else if (spur_req > spur_done) begin
            aes_done = 1'b1;
            aes_dout = {$urandom, $urandom, $urandom, $urandom};
            spur_done++;
        end
        if (rst && aes_start) begin
            start_count++;
            pending = 1'b1;
            wcnt    = 40;
            din_cap = aes_din;
        end
    end

    // UART sink: drives tx_ready, logs accepted bytes, watches stall stability.
    logic [7:0] tx_log [0:1023];
    int         tx_wr = 0;
    int         viol = 0;
    int         load_count = 0;
    int         tx_rise_cyc = -1;
    int         stall_until = 0;
    bit         rnd_ready = 1'b0;
    bit         prev_stall = 1'b0;
    bit         prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk) begin
        if (cyc < stall_until)  tx_ready = 1'b0;
        else if (rnd_ready)     tx_ready = 1'($urandom_range(0, 1));
        else                    tx_ready = 1'b1;
        if (rst && prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) viol++;
        if (tx_valid && !prev_valid) tx_rise_cyc = cyc;
        if (tx_valid && tx_ready) begin
            tx_log[tx_wr[9:0]] = tx_data;
            tx_wr++;
        end
        if (aes_key_load) load_count++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_valid = tx_valid;
    end

    int tx_rd = 0;

    task automatic send_byte(input logic [7:0] b, input bit err, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_data = b; rx_valid = 1'b1; rx_frame_err = err;
        @(negedge clk);
        rx_valid = 1'b0; rx_frame_err = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] blk);
        for (int i = 0; i < 16; i++)
            send_byte(blk[127-8*i -: 8], 1'b0, (i == 15) ? 0 : int'($urandom_range(0, 2)));
    endtask

    task automatic collect(output logic [127:0] got, output bit ok);
        int t = 0;
        while ((tx_wr - tx_rd) < 16 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        ok  = ((tx_wr - tx_rd) >= 16);
        got = '0;
        if (ok) begin
            for (int i = 0; i < 16; i++) begin
                got[127-8*i -: 8] = tx_log[tx_rd[9:0]];
                tx_rd++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx_valid !== 1'b0)     begin n_bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_cmp++; if (aes_key_load !== 1'b0) begin n_bad++; $display("FAIL reset_key_load: got %b want 0", aes_key_load); end
        n_cmp++; if (aes_start !== 1'b0)    begin n_bad++; $display("FAIL reset_start: got %b want 0", aes_start); end
        n_cmp++; if (key_loaded !== 1'b0)   begin n_bad++; $display("FAIL reset_key_loaded: got %b want 0", key_loaded); end
        n_cmp++; if (busy !== 1'b0)         begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if ({overrun, frame_err} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {overrun, frame_err}); end
        n_cmp++; if (aes_key !== '0)        begin n_bad++; $display("FAIL reset_key: got %h want 0", aes_key); end
        n_cmp++; if (aes_din !== '0)        begin n_bad++; $display("FAIL reset_din: got %h want 0", aes_din); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_key(input logic [7:0] kb [32]);
        logic [255:0] exp_key;
        int           l0;
        l0 = load_count;
        for (int i = 0; i < 32; i++) exp_key[255-8*i -: 8] = kb[i];
        for (int i = 0; i < 32; i++)
            send_byte(kb[i], 1'b0, (i == 31) ? 0 : int'($urandom_range(0, 2)));
        n_cmp++; if (aes_key_load !== 1'b1) begin n_bad++; $display("FAIL key_load_pulse: got %b want 1", aes_key_load); end
        n_cmp++; if (aes_key !== exp_key)   begin n_bad++; $display("FAIL key_value: got %h want %h", aes_key, exp_key); end
        n_cmp++; if (key_loaded !== 1'b1)   begin n_bad++; $display("FAIL key_loaded: got %b want 1", key_loaded); end
        @(negedge clk);
        n_cmp++; if (aes_key_load !== 1'b0) begin n_bad++; $display("FAIL key_load_width: got %b want 0", aes_key_load); end
        n_cmp++; if (load_count - l0 !== 1) begin n_bad++; $display("FAIL key_load_count: got %0d want 1", load_count - l0); end
    endtask

    task automatic test_vector();
        logic [127:0] got;
        bit           ok;
        send_block(PT);
        n_cmp++; if (aes_start !== 1'b1) begin n_bad++; $display("FAIL vec_start_pulse: got %b want 1", aes_start); end
        n_cmp++; if (aes_din !== PT)     begin n_bad++; $display("FAIL vec_din: got %h want %h", aes_din, PT); end
        n_cmp++; if (busy !== 1'b1)      begin n_bad++; $display("FAIL vec_busy: got %b want 1", busy); end
        collect(got, ok);
        n_cmp++; if (!ok || got !== CT)  begin n_bad++; $display("FAIL vec_result: got %h want %h (complete=%0d)", got, CT, ok); end
        n_cmp++; if (tx_rise_cyc !== done_cyc + 1) begin n_bad++; $display("FAIL vec_tx_latency: got %0d want %0d", tx_rise_cyc, done_cyc + 1); end
        repeat (4) @(negedge clk);
        n_cmp++; if (tx_wr !== tx_rd)    begin n_bad++; $display("FAIL vec_extra_bytes: got %0d want 0", tx_wr - tx_rd); end
        n_cmp++; if ({busy, tx_valid} !== 2'b00) begin n_bad++; $display("FAIL vec_idle: got %b want 00", {busy, tx_valid}); end
    endtask

    task automatic test_stall();
        logic [127:0] blk, got;
        bit           ok;
        blk = {$urandom, $urandom, $urandom, $urandom};
        send_block(blk);
        stall_until = cyc + 100;
        rnd_ready   = 1'b1;
        repeat (70) @(negedge clk);
        n_cmp++; if (tx_valid !== 1'b1 || tx_wr !== tx_rd) begin n_bad++; $display("FAIL stall_hold: got valid=%b sent=%0d want valid=1 sent=0", tx_valid, tx_wr - tx_rd); end
        collect(got, ok);
        rnd_ready = 1'b0;
        n_cmp++; if (!ok || got !== aes_model(blk)) begin n_bad++; $display("FAIL stall_result: got %h want %h", got, aes_model(blk)); end
        n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL stall_stability: got %0d violations want 0", viol); end
        repeat (4) @(negedge clk);
        n_cmp++; if (tx_wr !== tx_rd) begin n_bad++; $display("FAIL stall_extra_bytes: got %0d want 0", tx_wr - tx_rd); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] blk, got;
        bit           ok;
        int           s0, l0, good_bytes;
        s0 = start_count; l0 = load_count; good_bytes = 0;
        for (int b = 0; b < 5; b++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            send_block(blk);
            collect(got, ok);
            for (int i = 0; i < 16; i++)
                if (ok && got[127-8*i -: 8] === aes_model(blk)[127-8*i -: 8]) good_bytes++;
            n_cmp++; if (!ok || got !== aes_model(blk)) begin n_bad++; $display("FAIL b2b_result%0d: got %h want %h", b, got, aes_model(blk)); end
        end
        repeat (4) @(negedge clk);
        n_cmp++; if (good_bytes !== 80)          begin n_bad++; $display("FAIL b2b_bytes: got %0d want 80", good_bytes); end
        n_cmp++; if (start_count - s0 !== 5)     begin n_bad++; $display("FAIL b2b_starts: got %0d want 5", start_count - s0); end
        n_cmp++; if (load_count !== l0)          begin n_bad++; $display("FAIL b2b_key_reload: got %0d want %0d", load_count, l0); end
        n_cmp++; if (tx_wr !== tx_rd)            begin n_bad++; $display("FAIL b2b_extra_bytes: got %0d want 0", tx_wr - tx_rd); end
    endtask

    task automatic test_errors();
        logic [127:0] blk, got;
        bit           ok;
        blk = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 8; i++) send_byte(blk[127-8*i -: 8], 1'b0, 0);
        spur_req++;
        repeat (4) @(negedge clk);
        n_cmp++; if (tx_valid !== 1'b0 || tx_wr !== tx_rd) begin n_bad++; $display("FAIL err_stray_done: got valid=%b want 0", tx_valid); end
        send_byte(8'($urandom), 1'b1, 0);
        n_cmp++; if ({frame_err, overrun} !== 2'b10) begin n_bad++; $display("FAIL err_frame_flag: got %b want 10", {frame_err, overrun}); end
        for (int i = 8; i < 16; i++) send_byte(blk[127-8*i -: 8], 1'b0, 0);
        n_cmp++; if (aes_din !== blk) begin n_bad++; $display("FAIL err_din: got %h want %h", aes_din, blk); end
        send_byte(8'($urandom), 1'b0, 5);
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL err_overrun: got %b want 1", overrun); end
        collect(got, ok);
        n_cmp++; if (!ok || got !== aes_model(blk)) begin n_bad++; $display("FAIL err_result: got %h want %h", got, aes_model(blk)); end
        n_cmp++; if ({frame_err, overrun} !== 2'b11) begin n_bad++; $display("FAIL err_sticky: got %b want 11", {frame_err, overrun}); end
    endtask

    task automatic test_reset_mid();
        logic [7:0]   kb [32];
        logic [127:0] got;
        bit           ok;
        for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (key_loaded !== 1'b0) begin n_bad++; $display("FAIL rmid_key_loaded: got %b want 0", key_loaded); end
        n_cmp++; if ({frame_err, overrun} !== 2'b00) begin n_bad++; $display("FAIL rmid_flags: got %b want 00", {frame_err, overrun}); end
        n_cmp++; if (aes_key !== '0) begin n_bad++; $display("FAIL rmid_key_clear: got %h want 0", aes_key); end
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) kb[i] = 8'($urandom);
        test_key(kb);
        send_block(PT);
        collect(got, ok);
        n_cmp++; if (!ok || got !== CT) begin n_bad++; $display("FAIL rmid_result: got %h want %h", got, CT); end
    endtask

    initial begin
        logic [7:0] kb [32];
        for (int i = 0; i < 32; i++) kb[i] = 8'(i);
        test_reset();
        test_key(kb);
        test_vector();
        test_stall();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
